crc32_byte_engine: RTL
======================

# crc32_byte_engine

Byte-serial CRC-32 accumulator that sits directly upstream of the 256-entry CRC lookup-table stage. It takes a stream of 32-bit message words, drives one table address per cycle, and folds each returned table entry into a running CRC. When the last byte of a message has been folded in, it presents the finished CRC on a valid/ready output. The attached table holds the standard reflected CRC-32 byte table (polynomial 0xEDB88320).

## Interface
- INIT, 32'hFFFFFFFF, CRC register value at reset and at the start of each message
- XOROUT, 32'hFFFFFFFF, value XORed onto the CRC register to form out_crc
- clk  input  1  single clock, rising edge
- rstn  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  input word valid
- in_ready  output  1  engine accepts the word this cycle
- in_data  input  32  message word, byte 0 = in_data[7:0] processed first
- in_last  input  1  this word ends the message
- in_nbytes  input  2  valid bytes minus 1 on the last word (0 = 1 byte … 3 = 4 bytes); ignored when in_last=0, where all 4 bytes are valid
- tab_addr  output  32  table address, [31:8] always 0
- tab_rdata  input  32  table entry, combinational read of tab_addr
- out_valid  output  1  final CRC available
- out_ready  input  1  consumer accepts out_crc
- out_crc  output  32  crc_reg ^ XOROUT, valid while out_valid=1

## Operation
- Registers:
  - crc_reg[31:0]
  - word_reg[31:0]
  - byte_idx[1:0]
  - last_idx[1:0]
  - last_flag
  - state (IDLE, RUN, DONE)
- Reset (rstn=0, any time, mid-message included):
  - state=IDLE, crc_reg=INIT, byte_idx=0, word_reg=0
  - out_valid=0; in_ready=1 once rstn deasserts
  - Any partial message is discarded.
- Current byte: b = word_reg[8*byte_idx +: 8].
- Table address: tab_addr = {24'b0, crc_reg[7:0] ^ b} in RUN. In IDLE and DONE it is 0.
- Update in RUN, every cycle: crc_reg <= {8'b0, crc_reg[31:8]} ^ tab_rdata.
- in_ready = (state==IDLE) | (state==RUN & byte_idx==last_idx & !last_flag).
- On accept (in_valid & in_ready):
  - word_reg <= in_data, byte_idx <= 0, last_flag <= in_last
  - last_idx <= in_last ? in_nbytes : 3
  - state <= RUN
- RUN transitions:
  - byte_idx != last_idx: byte_idx increments.
  - Final byte of a non-last word: if a new word is accepted the same cycle, stay in RUN with no bubble. Otherwise go to IDLE; crc_reg is kept because the message is still open.
  - Final byte of the last word: go to DONE.
- Message-open tracking: IDLE with an open message does not reload INIT. INIT is reloaded only on the DONE→IDLE transition.
- DONE:
  - out_valid=1, in_ready=0; out_crc is held stable until out_ready=1.
  - On the handshake: state <= IDLE, crc_reg <= INIT, out_valid falls next cycle.
- Zero-length messages are not supported.

## Timing
- Throughput is 1 byte per clock while in_valid is held high.
- Words of a message are accepted every 4 clocks with no gap.
- Latency: the last word is accepted at edge E. With n = in_nbytes+1 valid bytes, out_valid rises at edge E+n.
- Output may be accepted on the first out_valid cycle. The next message's first word can then be accepted on the following cycle.
- The table read is combinational: tab_addr→tab_rdata must settle within one cycle. There are no registers on the table path inside this block.
- in_valid low between words of a message inserts idle cycles. The CRC result is unaffected.

## Test plan
- "123456789": words 0x34333231 and 0x38373635, then 0x00000039 with in_last=1, in_nbytes=0, in_valid held high → out_crc=0xCBF43926. out_valid rises 9 edges after the first accept.
- Single byte 0x00 (in_last=1, in_nbytes=0) → 0xD202EF8D. Single byte 0x61 ("a") → 0xE8B7BE43. Each has out_valid 1 edge after accept.
- Output backpressure: out_ready=0 for 5 cycles after out_valid → out_crc stable, in_ready=0 throughout. The next message accepted after the handshake gives the correct independent CRC (repeat "a" → 0xE8B7BE43).
- Gapped input: "123456789" with in_valid deasserted for 3 cycles between words → 0xCBF43926. Confirm tab_addr[31:8]=0 at all times.
- Reset mid-message: assert rstn=0 after 5 bytes of "123456789" → out_valid=0 and in_ready=1 immediately after release. A fresh "a" → 0xE8B7BE43.
- in_nbytes sweep: word 0x34333231 with in_last=1 and in_nbytes 0..3 → CRCs of "1", "12", "123", "1234" (0x83DCEFB7, 0x4F5344CD, 0x884863D2, 0x9BE3E0A3).

Source files
------------

// File: rtl/crc32_byte_engine.sv
// Byte-serial CRC-32 accumulator: folds one byte per clock through an external
// 256-entry reflected CRC-32 lookup table and presents the finished CRC on valid/ready.
module crc32_byte_engine #(
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_nbytes,
  output logic [31:0] tab_addr,
  input  logic [31:0] tab_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_crc
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] crc_reg;
  logic [31:0] word_reg;
  logic [1:0]  byte_idx;
  logic [1:0]  last_idx;
  logic        last_flag;

  logic [7:0]  cur_byte;
  logic        at_last_byte;
  logic        accept;

  assign cur_byte     = word_reg[{byte_idx, 3'b000} +: 8];
  assign at_last_byte = (byte_idx == last_idx);

  // A new word may be taken while the final byte of a non-final word is folded,
  // which keeps back-to-back words gapless.
  assign in_ready  = (state == IDLE) | ((state == RUN) & at_last_byte & ~last_flag);
  assign accept    = in_valid & in_ready;

  assign tab_addr  = (state == RUN) ? {24'b0, crc_reg[7:0] ^ cur_byte} : 32'b0;
  assign out_valid = (state == DONE);
  assign out_crc   = crc_reg ^ XOROUT;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      crc_reg   <= INIT;
      word_reg  <= 32'b0;
      byte_idx  <= 2'd0;
      last_idx  <= 2'd0;
      last_flag <= 1'b0;
    end else begin
      if (accept) begin
        word_reg  <= in_data;
        byte_idx  <= 2'd0;
        last_flag <= in_last;
        last_idx  <= in_last ? in_nbytes : 2'd3;
      end
      case (state)
        IDLE: begin
          // crc_reg is deliberately left alone here: a message may still be open.
          if (accept) state <= RUN;
        end
        RUN: begin
          crc_reg <= {8'b0, crc_reg[31:8]} ^ tab_rdata;
          if (!at_last_byte)  byte_idx <= byte_idx + 2'd1;
          else if (last_flag) state    <= DONE;
          else if (!accept)   state    <= IDLE;
        end
        DONE: begin
          if (out_ready) begin
            state   <= IDLE;
            crc_reg <= INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
